// File: rtl/branch_reservation_station.sv
// Branch reservation station: age-ordered compacting queue of branch ops waiting
// on operands, with CDB wakeup/forwarding and one registered issue per cycle.
module branch_reservation_station #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        disp_valid,
    output logic        disp_ready,
    input  logic [3:0]  disp_opcode,
    input  logic [3:0]  disp_rob_index,
    input  logic [8:0]  disp_i,
    input  logic        disp_t_rdy,
    input  logic        disp_a_rdy,
    input  logic        disp_b_rdy,
    input  logic [3:0]  disp_t_tag,
    input  logic [3:0]  disp_a_tag,
    input  logic [3:0]  disp_b_tag,
    input  logic [15:0] disp_t_val,
    input  logic [15:0] disp_a_val,
    input  logic [15:0] disp_b_val,
    input  logic        cdb_valid,
    input  logic [3:0]  cdb_tag,
    input  logic [15:0] cdb_value,
    output logic        out_valid,
    output logic [3:0]  out_opcode,
    output logic [3:0]  out_rob_index,
    output logic [15:0] out_vt,
    output logic [15:0] out_va,
    output logic [15:0] out_vb,
    output logic [8:0]  out_i
);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic        rdy;
        logic [3:0]  tag;
        logic [15:0] val;
    } operand_t;

    typedef struct packed {
        logic [3:0] opcode;
        logic [3:0] rob;
        logic [8:0] imm;
        operand_t   t;
        operand_t   a;
        operand_t   b;
    } entry_t;

    // Handshake: a dispatch is accepted on a rising edge when disp_valid && disp_ready
    // && !flush; disp_ready depends only on registered count. The issue side has no
    // ready: the branch unit takes every out_valid beat.
    entry_t        ent_q [DEPTH];
    entry_t        ent_d [DEPTH];
    entry_t        woke  [DEPTH];
    entry_t        new_ent;
    entry_t        sel_ent;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [CW-1:0] wr_idx;
    logic          issue;
    logic          do_disp;
    int            sel_idx;

    function automatic operand_t wake(input operand_t o, input logic v,
                                      input logic [3:0] tag, input logic [15:0] val);
        wake = o;
        if (v && !o.rdy && o.tag == tag) begin
            wake.rdy = 1'b1;
            wake.val = val;
        end
    endfunction

    assign disp_ready = (count_q < CW'(DEPTH));
    assign do_disp    = disp_valid && disp_ready && !flush;

    always_comb begin
        issue   = 1'b0;
        sel_idx = 0;
        sel_ent = '0;
        // Scan from the top so the lowest-index (oldest) eligible entry wins.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (CW'(i) < count_q && ent_q[i].t.rdy && ent_q[i].a.rdy && ent_q[i].b.rdy) begin
                issue   = 1'b1;
                sel_idx = i;
                sel_ent = ent_q[i];
            end
        end

        for (int i = 0; i < DEPTH; i++) begin
            woke[i]   = ent_q[i];
            woke[i].t = wake(ent_q[i].t, cdb_valid, cdb_tag, cdb_value);
            woke[i].a = wake(ent_q[i].a, cdb_valid, cdb_tag, cdb_value);
            woke[i].b = wake(ent_q[i].b, cdb_valid, cdb_tag, cdb_value);
        end

        for (int j = 0; j < DEPTH - 1; j++)
            ent_d[j] = (issue && j >= sel_idx) ? woke[j + 1] : woke[j];
        ent_d[DEPTH - 1] = woke[DEPTH - 1];

        new_ent.opcode = disp_opcode;
        new_ent.rob    = disp_rob_index;
        new_ent.imm    = disp_i;
        new_ent.t      = wake({disp_t_rdy, disp_t_tag, disp_t_val}, cdb_valid, cdb_tag, cdb_value);
        new_ent.a      = wake({disp_a_rdy, disp_a_tag, disp_a_val}, cdb_valid, cdb_tag, cdb_value);
        new_ent.b      = wake({disp_b_rdy, disp_b_tag, disp_b_val}, cdb_valid, cdb_tag, cdb_value);

        wr_idx = issue ? count_q - CW'(1) : count_q;
        if (do_disp) begin
            for (int j = 0; j < DEPTH; j++)
                if (CW'(j) == wr_idx) ent_d[j] = new_ent;
        end

        count_d = count_q;
        if (issue)   count_d = count_d - CW'(1);
        if (do_disp) count_d = count_d + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q       <= '0;
            out_valid     <= 1'b0;
            out_opcode    <= '0;
            out_rob_index <= '0;
            out_vt        <= '0;
            out_va        <= '0;
            out_vb        <= '0;
            out_i         <= '0;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
        end else if (flush) begin
            count_q   <= '0;
            out_valid <= 1'b0;
        end else begin
            count_q   <= count_d;
            out_valid <= issue;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
            if (issue) begin
                out_opcode    <= sel_ent.opcode;
                out_rob_index <= sel_ent.rob;
                out_vt        <= sel_ent.t.val;
                out_va        <= sel_ent.a.val;
                out_vb        <= sel_ent.b.val;
                out_i         <= sel_ent.imm;
            end
        end
    end
endmodule

// File: tb/tb_branch_reservation_station.sv
// Directed bench for branch_reservation_station: inputs change and outputs are
// checked just after each falling edge, so every step covers exactly one rising edge.
module tb_branch_reservation_station;
    logic        clk = 1'b0;
    logic        reset, flush, disp_valid, disp_ready;
    logic [3:0]  disp_opcode, disp_rob_index;
    logic [8:0]  disp_i;
    logic        disp_t_rdy, disp_a_rdy, disp_b_rdy;
    logic [3:0]  disp_t_tag, disp_a_tag, disp_b_tag;
    logic [15:0] disp_t_val, disp_a_val, disp_b_val;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [15:0] cdb_value;
    logic        out_valid;
    logic [3:0]  out_opcode, out_rob_index;
    logic [15:0] out_vt, out_va, out_vb;
    logic [8:0]  out_i;

    int checks = 0;
    int failures = 0;

    branch_reservation_station #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_opcode(disp_opcode), .disp_rob_index(disp_rob_index), .disp_i(disp_i),
        .disp_t_rdy(disp_t_rdy), .disp_a_rdy(disp_a_rdy), .disp_b_rdy(disp_b_rdy),
        .disp_t_tag(disp_t_tag), .disp_a_tag(disp_a_tag), .disp_b_tag(disp_b_tag),
        .disp_t_val(disp_t_val), .disp_a_val(disp_a_val), .disp_b_val(disp_b_val),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .out_valid(out_valid), .out_opcode(out_opcode), .out_rob_index(out_rob_index),
        .out_vt(out_vt), .out_va(out_va), .out_vb(out_vb), .out_i(out_i)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle();
        flush = 1'b0; disp_valid = 1'b0; cdb_valid = 1'b0;
    endtask

    // rdy = {t_rdy, a_rdy, b_rdy}
    task automatic drive_disp(input logic [3:0] op, input logic [3:0] rob, input logic [8:0] imm,
                              input logic [2:0] rdy, input logic [3:0] ttag, input logic [3:0] atag,
                              input logic [3:0] btag, input logic [15:0] tv, input logic [15:0] av,
                              input logic [15:0] bv);
        disp_valid = 1'b1; disp_opcode = op; disp_rob_index = rob; disp_i = imm;
        {disp_t_rdy, disp_a_rdy, disp_b_rdy} = rdy;
        disp_t_tag = ttag; disp_a_tag = atag; disp_b_tag = btag;
        disp_t_val = tv; disp_a_val = av; disp_b_val = bv;
    endtask

    task automatic drive_cdb(input logic [3:0] tag, input logic [15:0] value);
        cdb_valid = 1'b1; cdb_tag = tag; cdb_value = value;
    endtask

    task automatic test_reset();
        reset = 1'b1; idle();
        drive_disp(4'h8, 4'h0, 9'h0, 3'b000, 4'h0, 4'h0, 4'h0, 16'h0, 16'h0, 16'h0);
        disp_valid = 1'b0; cdb_tag = 4'h0; cdb_value = 16'h0;
        step(); step();
        reset = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if ({out_opcode, out_rob_index, out_i} !== 17'h0) begin failures++; $display("FAIL reset_out_ctrl got=%h exp=0", {out_opcode, out_rob_index, out_i}); end
        checks++; if ({out_vt, out_va, out_vb} !== 48'h0) begin failures++; $display("FAIL reset_out_vals got=%h exp=0", {out_vt, out_va, out_vb}); end
        checks++; if (disp_ready !== 1'b1) begin failures++; $display("FAIL reset_disp_ready got=%b exp=1", disp_ready); end
    endtask

    task automatic test_all_ready();
        drive_disp(4'b1000, 4'd3, 9'h1A5, 3'b111, 4'h0, 4'h0, 4'h0, 16'h1111, 16'h0000, 16'h2222);
        step(); idle();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ready_first_edge got=%b exp=0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL ready_issue_valid got=%b exp=1", out_valid); end
        checks++; if (out_rob_index !== 4'd3 || out_opcode !== 4'b1000) begin failures++; $display("FAIL ready_issue_id got=%h/%h exp=3/8", out_rob_index, out_opcode); end
        checks++; if (out_vt !== 16'h1111 || out_va !== 16'h0000 || out_vb !== 16'h2222) begin failures++; $display("FAIL ready_issue_vals got=%h/%h/%h exp=1111/0000/2222", out_vt, out_va, out_vb); end
        checks++; if (out_i !== 9'h1A5) begin failures++; $display("FAIL ready_issue_imm got=%h exp=1a5", out_i); end
        step();
        checks++; if (out_valid !== 1'b0 || out_rob_index !== 4'd3 || out_vt !== 16'h1111) begin failures++; $display("FAIL ready_hold got=%b/%h/%h exp=0/3/1111", out_valid, out_rob_index, out_vt); end
    endtask

    task automatic test_wakeup();
        drive_disp(4'b1010, 4'd5, 9'h003, 3'b101, 4'h0, 4'd7, 4'h0, 16'hAAAA, 16'hFFFF, 16'hBBBB);
        step(); idle();
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL wake_wait got=%b exp=0", out_valid); end
        drive_cdb(4'd7, 16'h0042);
        step(); idle();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL wake_no_comb_issue got=%b exp=0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b1 || out_rob_index !== 4'd5 || out_opcode !== 4'b1010) begin failures++; $display("FAIL wake_issue got=%b/%h/%h exp=1/5/a", out_valid, out_rob_index, out_opcode); end
        checks++; if (out_va !== 16'h0042 || out_vt !== 16'hAAAA || out_vb !== 16'hBBBB) begin failures++; $display("FAIL wake_vals got=%h/%h/%h exp=aaaa/0042/bbbb", out_vt, out_va, out_vb); end
    endtask

    task automatic test_forward();
        drive_disp(4'b1001, 4'd6, 9'h07F, 3'b110, 4'h0, 4'h0, 4'd2, 16'h0001, 16'h0002, 16'hDEAD);
        drive_cdb(4'd2, 16'h1234);
        step(); idle();
        step();
        checks++; if (out_valid !== 1'b1 || out_rob_index !== 4'd6) begin failures++; $display("FAIL fwd_issue got=%b/%h exp=1/6", out_valid, out_rob_index); end
        checks++; if (out_vb !== 16'h1234) begin failures++; $display("FAIL fwd_vb got=%h exp=1234", out_vb); end
        step();
    endtask

    task automatic test_full_and_flush();
        for (int k = 0; k < 4; k++) begin
            drive_disp(4'b1011, 4'(8 + k), 9'(k), 3'b101, 4'h0, 4'(8 + k), 4'h0, 16'h0, 16'h0, 16'h0);
            step();
        end
        idle();
        checks++; if (disp_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", disp_ready); end
        drive_disp(4'b1000, 4'd12, 9'h0, 3'b111, 4'h0, 4'h0, 4'h0, 16'h0, 16'h0, 16'h0);
        step(); idle();
        drive_cdb(4'd10, 16'h00AB);
        step(); idle();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL full_drop got=%b exp=0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b1 || out_rob_index !== 4'd10 || out_va !== 16'h00AB) begin failures++; $display("FAIL full_wake2 got=%b/%h/%h exp=1/a/00ab", out_valid, out_rob_index, out_va); end
        checks++; if (disp_ready !== 1'b1) begin failures++; $display("FAIL full_ready_after got=%b exp=1", disp_ready); end
        drive_disp(4'b1000, 4'd13, 9'h0, 3'b111, 4'h0, 4'h0, 4'h0, 16'h0, 16'h0, 16'h0);
        step(); idle();
        checks++; if (out_valid !== 1'b0 || disp_ready !== 1'b0) begin failures++; $display("FAIL full_refill got=%b/%b exp=0/0", out_valid, disp_ready); end
        drive_disp(4'b1000, 4'd14, 9'h0, 3'b111, 4'h0, 4'h0, 4'h0, 16'h0, 16'h0, 16'h0);
        step(); idle();
        checks++; if (out_valid !== 1'b1 || out_rob_index !== 4'd13 || disp_ready !== 1'b1) begin failures++; $display("FAIL full_issue_no_credit got=%b/%h/%b exp=1/d/1", out_valid, out_rob_index, disp_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL full_drop_at_depth got=%b exp=0", out_valid); end
        drive_cdb(4'd9, 16'h0099);
        step(); idle();
        flush = 1'b1;
        step(); idle();
        checks++; if (out_valid !== 1'b0 || disp_ready !== 1'b1) begin failures++; $display("FAIL flush_state got=%b/%b exp=0/1", out_valid, disp_ready); end
        for (int k = 8; k < 12; k++) begin
            drive_cdb(4'(k), 16'h0);
            step();
        end
        idle();
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_stale_tags got=%b exp=0", out_valid); end
        for (int k = 0; k < 4; k++) begin
            drive_disp(4'b1000, 4'd0, 9'h0, 3'b000, 4'd15, 4'd15, 4'd15, 16'h0, 16'h0, 16'h0);
            step();
        end
        idle();
        checks++; if (disp_ready !== 1'b0) begin failures++; $display("FAIL flush_count_zero got=%b exp=0", disp_ready); end
        flush = 1'b1;
        step(); idle();
    endtask

    task automatic test_back_to_back();
        drive_disp(4'b1000, 4'd1, 9'h011, 3'b101, 4'h0, 4'd3, 4'h0, 16'h0, 16'h0, 16'h0);
        step();
        drive_disp(4'b1001, 4'd2, 9'h022, 3'b110, 4'h0, 4'h0, 4'd3, 16'h0, 16'h0, 16'h0);
        step(); idle();
        drive_cdb(4'd3, 16'h0333);
        step(); idle();
        step();
        checks++; if (out_valid !== 1'b1 || out_rob_index !== 4'd1 || out_va !== 16'h0333) begin failures++; $display("FAIL order_first got=%b/%h/%h exp=1/1/0333", out_valid, out_rob_index, out_va); end
        step();
        checks++; if (out_valid !== 1'b1 || out_rob_index !== 4'd2 || out_vb !== 16'h0333) begin failures++; $display("FAIL order_second got=%b/%h/%h exp=1/2/0333", out_valid, out_rob_index, out_vb); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL order_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_reset_mid();
        drive_disp(4'b1000, 4'd4, 9'h044, 3'b111, 4'h0, 4'h0, 4'h0, 16'h4444, 16'h4444, 16'h4444);
        step();
        reset = 1'b1; flush = 1'b1;
        drive_disp(4'b1000, 4'd7, 9'h077, 3'b111, 4'h0, 4'h0, 4'h0, 16'h7777, 16'h7777, 16'h7777);
        step();
        reset = 1'b0; idle();
        checks++; if (out_valid !== 1'b0 || out_rob_index !== 4'd0 || out_va !== 16'h0) begin failures++; $display("FAIL rstmid_out got=%b/%h/%h exp=0/0/0", out_valid, out_rob_index, out_va); end
        step();
        checks++; if (out_valid !== 1'b0 || disp_ready !== 1'b1) begin failures++; $display("FAIL rstmid_discard got=%b/%b exp=0/1", out_valid, disp_ready); end
    endtask

    initial begin
        test_reset();
        test_all_ready();
        test_wakeup();
        test_forward();
        test_full_and_flush();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
